// File: rtl/img_mem_seq_if.sv
// Bundle between the image memory sequencer, the word memory and the processing unit.
// master = sequencer side; slave = memory, processing unit and top-level controller.
interface img_mem_seq_if;
    logic        start;
    logic [7:0]  mem_rd_adr;
    logic [31:0] mem_rd_data;
    logic        mem_write_en;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        proc_done;
    logic [3:0]  pass_idx;
    logic        busy;
    logic        done;

    modport master (
        input  start, mem_rd_data, out_ready, proc_done,
        output mem_rd_adr, mem_write_en, out_data, out_valid, out_last, pass_idx, busy, done
    );

    modport slave (
        output start, mem_rd_data, out_ready, proc_done,
        input  mem_rd_adr, mem_write_en, out_data, out_valid, out_last, pass_idx, busy, done
    );
endinterface

// File: rtl/img_mem_seq_ctrl.sv
// Image word memory sequencer: streams NUM_WORDS words per pass, waits for processing,
// pulses write-back, repeats NUM_PASSES times and signals done.
module img_mem_seq_ctrl #(
    parameter int unsigned BASE_RD_ADR = 0,
    parameter int unsigned NUM_WORDS   = 16,
    parameter int unsigned NUM_PASSES  = 4
) (
    input  logic           clk,
    input  logic           rst,
    img_mem_seq_if.master  bus
);
    localparam int unsigned ADR_W  = 8;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned PASS_W = 4;

    localparam logic [ADR_W-1:0]  BASE_ADR  = ADR_W'(BASE_RD_ADR);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_WORDS - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);
    localparam logic              ONE_WORD  = (NUM_WORDS == 1);

    if (NUM_WORDS < 1 || NUM_WORDS > 256) begin : g_bad_words
        $error("img_mem_seq_ctrl: NUM_WORDS must be 1..256");
    end
    if (NUM_PASSES < 1 || NUM_PASSES > 16) begin : g_bad_passes
        $error("img_mem_seq_ctrl: NUM_PASSES must be 1..16");
    end
    if (BASE_RD_ADR + NUM_WORDS - 1 > 255) begin : g_bad_range
        $error("img_mem_seq_ctrl: BASE_RD_ADR+NUM_WORDS-1 exceeds 255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_PROC,
        S_WRITE,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADR_W-1:0]    adr_q, adr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                mem_write_en_q, mem_write_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Next-state and registered-output decode; pulses default low every cycle
    always_comb begin
        state_d        = state_q;
        adr_d          = adr_q;
        cnt_d          = cnt_q;
        pass_d         = pass_q;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        busy_d         = busy_q;
        mem_write_en_d = 1'b0;
        done_d         = 1'b0;
        cnt_inc        = cnt_q + CNT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_READ;
                    adr_d       = BASE_ADR;
                    cnt_d       = '0;
                    pass_d      = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = ONE_WORD;
                    busy_d      = 1'b1;
                end
            end
            S_READ: begin
                if (bus.out_ready) begin
                    if (cnt_q == LAST_CNT) begin
                        // Final beat: park the address back at the base, never past the last word
                        state_d     = S_WAIT_PROC;
                        adr_d       = BASE_ADR;
                        cnt_d       = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        adr_d      = adr_q + ADR_W'(1);
                        cnt_d      = cnt_inc;
                        out_last_d = (cnt_inc == LAST_CNT);
                    end
                end
            end
            S_WAIT_PROC: begin
                if (bus.proc_done) begin
                    state_d        = S_WRITE;
                    mem_write_en_d = 1'b1;
                end
            end
            S_WRITE: begin
                if (pass_q < LAST_PASS) begin
                    state_d     = S_READ;
                    pass_d      = pass_q + PASS_W'(1);
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = ONE_WORD;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            adr_q          <= BASE_ADR;
            cnt_q          <= '0;
            pass_q         <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            mem_write_en_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            adr_q          <= adr_d;
            cnt_q          <= cnt_d;
            pass_q         <= pass_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            mem_write_en_q <= mem_write_en_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign bus.mem_rd_adr   = adr_q;
    assign bus.out_data     = bus.mem_rd_data;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
    assign bus.mem_write_en = mem_write_en_q;
    assign bus.pass_idx     = pass_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule
